// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command/register controller: FSM encoding,
// command-word layout and the default status byte.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WR       = 3'd2,
        RD_FETCH = 3'd3,
        RD       = 3'd4
    } ctrl_state_t;

    // The read/write flag is the MSB of the command word; offset counted from the MSB.
    localparam int CMD_WR_BIT_FROM_MSB = 0;

    localparam logic [7:0] DEFAULT_STATUS_WORD = 8'hA5;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for asynchronous input pins.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frame decoder behind an SPI slave: turns command/data words into register-file
// reads and writes with an auto-incrementing address, and sequences MISO data.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int                  WORDSIZE    = 8,
    parameter int                  ADDR_BITS   = 4,
    parameter logic [WORDSIZE-1:0] STATUS_WORD = WORDSIZE'(DEFAULT_STATUS_WORD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss,
    input  logic                 spi_done,
    input  logic [WORDSIZE-1:0]  spi_dout,
    output logic [WORDSIZE-1:0]  spi_din,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [WORDSIZE-1:0]  reg_wdata,
    output logic                 reg_we,
    input  logic [WORDSIZE-1:0]  reg_rdata,
    output logic                 busy,
    output logic                 frame_end
);

    logic                 ss_s;
    logic                 ss_s_d_reg;
    logic                 ss_rise;
    logic                 ss_fall;

    ctrl_state_t          state_reg, state_next;
    logic [ADDR_BITS-1:0] ptr_reg, ptr_next;
    logic [ADDR_BITS-1:0] reg_addr_reg, reg_addr_next;
    logic [WORDSIZE-1:0]  reg_wdata_reg, reg_wdata_next;
    logic                 reg_we_reg, reg_we_next;
    logic [WORDSIZE-1:0]  spi_din_reg, spi_din_next;
    logic                 cap_reg, cap_next;
    logic                 frame_end_reg, frame_end_next;

    logic [ADDR_BITS-1:0] cmd_addr;
    logic                 cmd_is_write;
    logic                 unused_dout_bits;

    // Sync and edge register reset to "selected": a falling edge then needs a
    // genuinely sampled high, so a frame already running at reset release is ignored.
    sync_2ff #(
        .RST_VAL(1'b0)
    ) u_ss_sync (
        .clk(clk),
        .rst(rst),
        .d  (ss),
        .q  (ss_s)
    );

    assign ss_rise = ss_s & ~ss_s_d_reg;
    assign ss_fall = ~ss_s & ss_s_d_reg;

    assign cmd_is_write     = spi_dout[WORDSIZE-1-CMD_WR_BIT_FROM_MSB];
    assign cmd_addr         = spi_dout[ADDR_BITS-1:0];
    // Command bits between the flag and the address field are don't-care.
    assign unused_dout_bits = ^spi_dout;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        reg_addr_next  = reg_addr_reg;
        reg_wdata_next = reg_wdata_reg;
        reg_we_next    = 1'b0;
        spi_din_next   = spi_din_reg;
        cap_next       = 1'b0;
        frame_end_next = 1'b0;

        // Read data is valid one cycle after the address was presented.
        if (cap_reg) begin
            spi_din_next = reg_rdata;
        end

        case (state_reg)
            IDLE: begin
                spi_din_next = STATUS_WORD;
                if (ss_fall) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (spi_done) begin
                    ptr_next = cmd_addr;
                    if (cmd_is_write) begin
                        state_next = WR;
                    end else begin
                        reg_addr_next = cmd_addr;
                        state_next    = RD_FETCH;
                    end
                end
            end
            WR: begin
                if (spi_done) begin
                    reg_we_next    = 1'b1;
                    reg_addr_next  = ptr_reg;
                    reg_wdata_next = spi_dout;
                    ptr_next       = ptr_reg + ADDR_BITS'(1);
                end
            end
            RD_FETCH: begin
                cap_next   = 1'b1;
                state_next = RD;
            end
            RD: begin
                if (spi_done) begin
                    ptr_next      = ptr_reg + ADDR_BITS'(1);
                    reg_addr_next = ptr_reg + ADDR_BITS'(1);
                    state_next    = RD_FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A word finishing together with the ss rise is still committed above.
        if (state_reg != IDLE && ss_rise) begin
            state_next     = IDLE;
            frame_end_next = 1'b1;
            cap_next       = 1'b0;
            spi_din_next   = STATUS_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_s_d_reg    <= 1'b0;
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            reg_addr_reg  <= '0;
            reg_wdata_reg <= '0;
            reg_we_reg    <= 1'b0;
            spi_din_reg   <= STATUS_WORD;
            cap_reg       <= 1'b0;
            frame_end_reg <= 1'b0;
        end else begin
            ss_s_d_reg    <= ss_s;
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            reg_addr_reg  <= reg_addr_next;
            reg_wdata_reg <= reg_wdata_next;
            reg_we_reg    <= reg_we_next;
            spi_din_reg   <= spi_din_next;
            cap_reg       <= cap_next;
            frame_end_reg <= frame_end_next;
        end
    end

    assign spi_din   = spi_din_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    // A strobe pending when rst arrives is dropped in the same cycle.
    assign reg_we    = reg_we_reg & ~rst;
    assign busy      = ~ss_s & (state_reg != IDLE);
    assign frame_end = frame_end_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed plus randomized frames for spi_reg_ctrl, checked against a
// frame-level model of register contents, MISO words and write strobes.
module tb_spi_reg_ctrl;

    localparam int         W      = 8;
    localparam int         AB     = 4;
    localparam logic [7:0] STATUS = 8'hA5;
    localparam int         GAP    = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss;
    logic       spi_done;
    logic [7:0] spi_dout;
    logic [7:0] spi_din;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       frame_end;

    always #5 clk = ~clk;

    spi_reg_ctrl #(
        .WORDSIZE   (W),
        .ADDR_BITS  (AB),
        .STATUS_WORD(STATUS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ss       (ss),
        .spi_done (spi_done),
        .spi_dout (spi_dout),
        .spi_din  (spi_din),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_rdata(reg_rdata),
        .busy     (busy),
        .frame_end(frame_end)
    );

    // Register file attached to the DUT: registered read, one-cycle latency.
    logic [7:0] rf [16];
    always @(posedge clk) begin
        if (reg_we) rf[reg_addr] <= reg_wdata;
        reg_rdata <= rf[reg_addr];
    end

    logic [3:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         fe_count;

    always @(negedge clk) begin
        if (reg_we === 1'b1) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (frame_end === 1'b1) fe_count++;
    end

    logic [7:0] model_mem [16];
    logic [7:0] tx_data [$];
    logic [7:0] tx_next;
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor();
        wr_addr_q.delete();
        wr_data_q.delete();
        fe_count = 0;
    endtask

    // The slave loads its shift register from spi_din while ss is high.
    task automatic start_frame();
        @(negedge clk) tx_next = spi_din;
        @(posedge clk) #1 ss = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, output logic [7:0] miso);
        miso = tx_next;
        repeat (GAP) @(posedge clk);
        #1 spi_done = 1'b1; spi_dout = d;
        @(negedge clk) tx_next = spi_din;
        @(posedge clk) #1 spi_done = 1'b0; spi_dout = '0;
    endtask

    // Last word completes in the very cycle the synchronized ss rises.
    task automatic send_word_coincident(input logic [7:0] d, output logic [7:0] miso);
        miso = tx_next;
        repeat (GAP) @(posedge clk);
        #1 ss = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 spi_done = 1'b1; spi_dout = d;
        @(negedge clk) tx_next = spi_din;
        @(posedge clk) #1 spi_done = 1'b0; spi_dout = '0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        repeat (GAP) @(posedge clk);
        #1 ss = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input bit coincide);
        logic [7:0] miso;
        logic [7:0] exp_miso;
        int         start;
        bit         is_wr;
        int         n;
        start = int'(cmd[3:0]);
        is_wr = cmd[7];
        n     = tx_data.size();
        clear_monitor();
        start_frame();
        send_word(cmd, miso);
        check("miso_cmd_word", miso, STATUS);
        check("busy_in_frame", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (coincide && i == n - 1) send_word_coincident(tx_data[i], miso);
            else                        send_word(tx_data[i], miso);
            exp_miso = (is_wr || i == 0) ? STATUS : model_mem[(start + i - 1) % 16];
            check($sformatf("miso_word%0d", i + 2), miso, exp_miso);
        end
        if (!coincide) end_frame();
        check("write_count", wr_addr_q.size(), is_wr ? n : 0);
        if (is_wr) begin
            for (int j = 0; j < n && j < wr_addr_q.size(); j++) begin
                check($sformatf("write%0d_addr", j), wr_addr_q[j], (start + j) % 16);
                check($sformatf("write%0d_data", j), wr_data_q[j], tx_data[j]);
            end
            for (int j = 0; j < n; j++) model_mem[(start + j) % 16] = tx_data[j];
        end
        check("frame_end_count", fe_count, 1);
        check("busy_after_frame", busy, 0);
        $display("frame cmd=%02h data_words=%0d writes=%0d frame_end=%0d", cmd, n, wr_addr_q.size(), fe_count);
    endtask

    initial begin
        logic [7:0] miso;
        logic [7:0] cmd;
        int         n;

        rst = 1'b1; ss = 1'b1; spi_done = 1'b0; spi_dout = '0;
        fe_count = 0; tx_next = STATUS;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_spi_din", spi_din, STATUS);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_end", frame_end, 0);
        @(posedge clk) #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("no_frame_end_after_reset", fe_count, 0);

        // Fill every register so the model is fully defined; also wraps 15 -> 0.
        tx_data.delete();
        for (int i = 0; i < 16; i++) tx_data.push_back(8'($urandom));
        run_frame(8'h80, 1'b0);

        tx_data = '{8'h11, 8'h22};
        run_frame(8'h83, 1'b0);

        tx_data = '{8'h5A, 8'hC3};
        run_frame(8'h85, 1'b0);
        tx_data = '{8'h00, 8'h00, 8'h00};
        run_frame(8'h05, 1'b0);
        check("read_reg5_model", model_mem[5], 8'h5A);

        tx_data = '{8'h01, 8'h02};
        run_frame(8'h8F, 1'b0);

        // Abort: ss rises four bit-times into the second word.
        clear_monitor();
        start_frame();
        send_word(8'h87, miso);
        repeat (4) @(posedge clk);
        #1 ss = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_writes", wr_addr_q.size(), 0);
        check("abort_frame_end", fe_count, 1);
        check("abort_busy", busy, 0);
        $display("frame cmd=87 aborted writes=%0d frame_end=%0d", wr_addr_q.size(), fe_count);
        tx_data = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(8'h07, 1'b0);

        // Reset right after a write data word completes, ss held low throughout.
        clear_monitor();
        start_frame();
        send_word(8'h82, miso);
        repeat (GAP) @(posedge clk);
        #1 spi_done = 1'b1; spi_dout = 8'h99;
        @(posedge clk) #1 spi_done = 1'b0; spi_dout = '0; rst = 1'b1;
        @(negedge clk);
        check("we_dropped_by_rst", reg_we, 0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_spi_din", spi_din, STATUS);
        check("midrst_reg_addr", reg_addr, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk) #1 rst = 1'b0;
        tx_next = STATUS;
        send_word(8'h84, miso);
        send_word(8'h55, miso);
        send_word(8'h66, miso);
        check("postrst_busy", busy, 0);
        end_frame();
        check("postrst_writes", wr_addr_q.size(), 0);
        check("postrst_frame_end", fe_count, 0);
        $display("frame cmd=82 reset mid-frame writes=%0d frame_end=%0d", wr_addr_q.size(), fe_count);
        tx_data = '{8'h00, 8'h00, 8'h00};
        run_frame(8'h01, 1'b0);

        tx_data = '{8'($urandom), 8'($urandom)};
        run_frame(8'h8A, 1'b1);

        for (int r = 0; r < 12; r++) begin
            cmd = 8'($urandom);
            n   = int'($urandom_range(1, 5));
            tx_data.delete();
            for (int i = 0; i < n; i++) tx_data.push_back(8'($urandom));
            run_frame(cmd, (r % 4 == 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
